vproc_unit_queue: RTL and testbench
===================================

Name: vproc_unit_queue

Overview:
- Per-unit instruction queue on the issue side of every vproc_pipeline instance; drives the op_rdy/op_ack handshake that a pipeline consumes.
- Buffers decoded vector ops from the dispatcher and presents the oldest op to the pipeline.
- Silently drops ops killed by the core and reports them as done.
- Exports the OR of pending vreg write masks of all queued ops for hazard checking.

Parameters:
- DEPTH, 4, number of queue entries; power of two, at least 2.
- XIF_ID_W, 3, instruction ID width in bits.
- XIF_ID_CNT, 8, total number of instruction IDs.
- OP_W, 64, width of the opaque packed op payload (vproc_pkg::unit_op packing; ID excluded).

Ports:
- clk_i  in  1  clock
- async_rst_i  in  1  asynchronous active-high reset
- enq_valid_i  in  1  dispatcher offers an op
- enq_ready_o  out  1  queue accepts the offered op
- enq_id_i  in  XIF_ID_W  instruction ID of the offered op
- enq_op_i  in  OP_W  packed op payload
- enq_pend_wr_i  in  32  vregs the op will write
- op_rdy_o  out  1  head op valid toward the pipeline
- op_ack_i  in  1  pipeline consumes the head op
- op_id_o  out  XIF_ID_W  head op ID
- op_o  out  OP_W  head op payload
- instr_killed_i  in  XIF_ID_CNT  per-ID kill flags from the core
- kill_done_valid_o  out  1  a killed op was dropped this cycle
- kill_done_id_o  out  XIF_ID_W  ID of the dropped op
- vreg_pend_wr_o  out  32  OR of enq_pend_wr of all valid entries
- count_o  out  $clog2(DEPTH)+1  number of occupied entries

Behaviour:
- Storage: circular buffer with rd_ptr and wr_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH, plus a count register.
- Reset (async, active-high):
  - rd_ptr, wr_ptr and count cleared to 0.
  - All entry valid bits cleared.
  - Output reset values: op_rdy_o=0, kill_done_valid_o=0, kill_done_id_o=0, vreg_pend_wr_o=0, count_o=0, enq_ready_o=1.
  - Payload registers are not reset; op_o and op_id_o are don't-care while op_rdy_o=0.
- Enqueue:
  - enq_ready_o = (count != DEPTH); depends only on registered state.
  - A transfer occurs when enq_valid_i & enq_ready_o; the entry is written at wr_ptr and wr_ptr advances.
- Head states (combinational on registered state):
  - EMPTY: count==0. op_rdy_o=0.
  - LIVE: count>0 and instr_killed_i[head_id]==0. op_rdy_o=1.
  - KILLED: count>0 and instr_killed_i[head_id]==1. op_rdy_o=0.
- Dequeue in LIVE: op_ack_i pops the head and advances rd_ptr. The pipeline must only assert op_ack_i while op_rdy_o=1; op_ack_i is ignored otherwise.
- Dequeue in KILLED: the head is popped automatically that cycle. kill_done_valid_o pulses for one cycle, registered, in the next cycle, with kill_done_id_o = the dropped ID. At most one kill drop per cycle.
- Simultaneous enqueue and dequeue while full: enq_ready_o is 0, so the enqueue is not accepted that cycle (no pass-through when full).
- Simultaneous enqueue and dequeue at any other fill level: count is unchanged and both pointers advance.
- vreg_pend_wr_o:
  - Registered.
  - Next value = OR of pend_wr over the entries valid after this cycle's updates, so it includes a same-cycle enqueue and excludes a same-cycle pop.
  - Latency: 1 cycle after the enqueue or pop.
- Ops handed to the pipeline are no longer tracked; the pipeline reports its own hazards.
- instr_killed_i is only inspected at the head; a killed non-head entry is dropped when it reaches the head.
- Reset while busy: all entries are discarded with no kill_done reports.

Optional Feature:
- Macro: VPROC_UNIT_QUEUE_BYPASS_EN.
- Defined: when count==0 and enq_valid_i=1, op_rdy_o=1 in the same cycle with op_o/op_id_o taken from enq_*.
  - If op_ack_i is also asserted that cycle, the op is consumed and not written.
  - Otherwise it is written normally.
  - Kill flags also apply to the bypassed op: if the op is killed, it is enqueued rather than bypassed.
- Undefined: minimum enqueue-to-op_rdy_o latency is 1 cycle.

Decomposition:
- vproc_pkg gets:
  - the unit_op packed struct (mode, widenarrow, rs1, rs2, vd, vsew, emul, vxrm, vl, vl_0);
  - a localparam UNIT_OP_W = $bits(unit_op).
- Natural sub-module: vproc_unit_queue_mem, holding the entry array (payload, ID, pend_wr, valid) with one write port, one read port, and the OR-reduction of pend_wr.

Test Plan:
- Fill and drain:
  - enqueue IDs 0,1,2,3 with op_ack_i held low: count_o reaches 4 and enq_ready_o=0.
  - then assert op_ack_i for 4 cycles: op_id_o presents 0,1,2,3 in order, count_o ends at 0.
- Pending mask:
  - enqueue pend_wr 0x0000_0003, then 0x0000_0030: vreg_pend_wr_o shows 0x03, then 0x33.
  - acking the first op gives 0x30 one cycle after the ack.
- Kill at head:
  - queue IDs 2 and 5, set instr_killed_i[2]=1.
  - required: op_rdy_o=0 that cycle, next cycle kill_done_valid_o=1 with ID 2, then op_rdy_o=1 with op_id_o=5.
- Wrap-around plus simultaneous traffic:
  - run 10 ops with enqueue and ack in the same cycle at count 2.
  - required: in-order IDs 0..9 mod 8, count stays 2, no losses.
- Full with pop:
  - with count 4, assert enq_valid_i and op_ack_i together.
  - required: no enqueue that cycle, count 3; the enqueue is accepted the next cycle.
- Reset mid-operation:
  - assert async_rst_i with 3 entries queued.
  - required: outputs immediately return to their reset values with no kill_done pulse; with VPROC_UNIT_QUEUE_BYPASS_EN, an enqueue+ack while empty gives a 0-cycle handoff and count stays 0.

Source files
------------

// File: rtl/vproc_pkg.sv
// -----------------------------------------------------------------------------
// vproc_pkg
//
// Shared types for the vector processor issue side.
//   unit_op       : packed decoded op handed from the dispatcher to a unit
//                   pipeline (the instruction ID travels separately).
//   UNIT_OP_W     : width of unit_op in bits.
//   head_state_e  : classification of the head entry of a unit queue.
// -----------------------------------------------------------------------------
package vproc_pkg;

  typedef struct packed {
    logic [3:0]  mode;        // unit-specific operation selector
    logic [1:0]  widenarrow;  // widening / narrowing control
    logic [5:0]  rs1;         // {is_vreg, index} of first source
    logic [5:0]  rs2;         // {is_vreg, index} of second source
    logic [4:0]  vd;          // destination vreg
    logic [2:0]  vsew;        // element width
    logic [2:0]  emul;        // effective LMUL
    logic [1:0]  vxrm;        // fixed-point rounding mode
    logic [31:0] vl;          // vector length
    logic        vl_0;        // vl is zero
  } unit_op;

  localparam int unsigned UNIT_OP_W = $bits(unit_op);

  // EMPTY  : no entry queued.
  // LIVE   : head entry may be handed to the pipeline.
  // KILLED : head entry was killed by the core and is dropped this cycle.
  typedef enum logic [1:0] {
    HEAD_EMPTY  = 2'd0,
    HEAD_LIVE   = 2'd1,
    HEAD_KILLED = 2'd2
  } head_state_e;

endpackage

// File: rtl/vproc_unit_queue_mem.sv
// -----------------------------------------------------------------------------
// vproc_unit_queue_mem
//
// Entry storage for vproc_unit_queue: payload, ID, pending vreg write mask
// and a valid bit per entry. One write port, one read port, one clear port.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset (valid bits only)
//   wr_en/wr_addr       write an entry (sets its valid bit)
//   wr_id/wr_op/wr_pend data written
//   rd_addr             read address; rd_id/rd_op are combinational
//   clr_en/clr_addr     clear the valid bit of a popped entry
//   pend_next           OR of pend masks over entries valid after this
//                       cycle's write/clear (owner registers it)
// -----------------------------------------------------------------------------
module vproc_unit_queue_mem #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ID_W  = 3,
  parameter int unsigned OP_W  = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [ID_W-1:0] wr_id,
  input  logic [OP_W-1:0] wr_op,
  input  logic [31:0]     wr_pend,
  input  logic [AW-1:0]   rd_addr,
  output logic [ID_W-1:0] rd_id,
  output logic [OP_W-1:0] rd_op,
  input  logic            clr_en,
  input  logic [AW-1:0]   clr_addr,
  output logic [31:0]     pend_next
);

  logic [OP_W-1:0]  op_mem   [DEPTH];
  logic [ID_W-1:0]  id_mem   [DEPTH];
  logic [31:0]      pend_mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] valid_next;

  // Payload is not reset; it is only observed behind a valid bit / count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      op_mem[wr_addr]   <= wr_op;
      id_mem[wr_addr]   <= wr_id;
      pend_mem[wr_addr] <= wr_pend;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else begin
      valid <= valid_next;
    end
  end

  // A write and a clear never target the same slot: that would need the
  // queue to be full (writes blocked) or empty (nothing to clear).
  always_comb begin
    valid_next = valid;
    if (clr_en) valid_next[clr_addr] = 1'b0;
    if (wr_en)  valid_next[wr_addr]  = 1'b1;
  end

  // The slot being written this cycle contributes its incoming mask, since
  // pend_mem does not hold it yet.
  always_comb begin
    pend_next = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (valid_next[i]) begin
        if (wr_en && (wr_addr == AW'(i))) begin
          pend_next = pend_next | wr_pend;
        end else begin
          pend_next = pend_next | pend_mem[i];
        end
      end
    end
  end

  assign rd_id = id_mem[rd_addr];
  assign rd_op = op_mem[rd_addr];

endmodule

// File: rtl/vproc_unit_queue.sv
// -----------------------------------------------------------------------------
// vproc_unit_queue
//
// Per-unit instruction queue in front of a vproc pipeline. Buffers decoded
// ops from the dispatcher, presents the oldest one through op_rdy/op_ack,
// drops ops killed by the core (reporting them on kill_done_*), and exports
// the OR of pending vreg write masks of all queued ops.
//
// Handshakes (valid/ready semantics):
//   enq  : a transfer happens in a cycle where enq_valid_i & enq_ready_o.
//          enq_ready_o depends on registered state only.
//   op   : the head op is consumed in a cycle where op_rdy_o & op_ack_i;
//          op_ack_i while op_rdy_o=0 has no effect.
//
// Ports:
//   clk_i, async_rst_i           clock, asynchronous active-high reset
//   enq_valid_i/enq_ready_o      dispatcher handshake
//   enq_id_i/enq_op_i/enq_pend_wr_i  offered op
//   op_rdy_o/op_ack_i            pipeline handshake
//   op_id_o/op_o                 head op (don't-care while op_rdy_o=0)
//   instr_killed_i               per-ID kill flags, inspected at the head
//   kill_done_valid_o/_id_o      registered one-cycle report of a dropped op
//   vreg_pend_wr_o               registered OR of pending write masks
//   count_o                      number of occupied entries
//
// Build option:
//   VPROC_UNIT_QUEUE_BYPASS_EN   when defined, an op offered to an empty
//                                queue is presented on op_* in the same
//                                cycle; if acked it is never written.
// -----------------------------------------------------------------------------
module vproc_unit_queue
  import vproc_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned XIF_ID_W   = 3,
  parameter int unsigned XIF_ID_CNT = 8,
  parameter int unsigned OP_W       = UNIT_OP_W
) (
  input  logic                       clk_i,
  input  logic                       async_rst_i,
  input  logic                       enq_valid_i,
  output logic                       enq_ready_o,
  input  logic [XIF_ID_W-1:0]        enq_id_i,
  input  logic [OP_W-1:0]            enq_op_i,
  input  logic [31:0]                enq_pend_wr_i,
  output logic                       op_rdy_o,
  input  logic                       op_ack_i,
  output logic [XIF_ID_W-1:0]        op_id_o,
  output logic [OP_W-1:0]            op_o,
  input  logic [XIF_ID_CNT-1:0]      instr_killed_i,
  output logic                       kill_done_valid_o,
  output logic [XIF_ID_W-1:0]        kill_done_id_o,
  output logic [31:0]                vreg_pend_wr_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0]       rd_ptr;
  logic [AW-1:0]       wr_ptr;
  logic [CW-1:0]       count;
  head_state_e         head_state;
  logic [XIF_ID_W-1:0] head_id;
  logic [OP_W-1:0]     head_op;
  logic                push;
  logic                wr_en;
  logic                pop;
  logic                pop_kill;
  logic [31:0]         pend_next;

  vproc_unit_queue_mem #(
    .DEPTH (DEPTH),
    .ID_W  (XIF_ID_W),
    .OP_W  (OP_W),
    .AW    (AW)
  ) u_mem (
    .clk       (clk_i),
    .rst       (async_rst_i),
    .wr_en     (wr_en),
    .wr_addr   (wr_ptr),
    .wr_id     (enq_id_i),
    .wr_op     (enq_op_i),
    .wr_pend   (enq_pend_wr_i),
    .rd_addr   (rd_ptr),
    .rd_id     (head_id),
    .rd_op     (head_op),
    .clr_en    (pop),
    .clr_addr  (rd_ptr),
    .pend_next (pend_next)
  );

  // Head classification from registered state and the live kill flags.
  always_comb begin
    head_state = HEAD_EMPTY;
    if (count != '0) begin
      head_state = instr_killed_i[head_id] ? HEAD_KILLED : HEAD_LIVE;
    end
  end

  always_comb begin
    enq_ready_o = (count != CW'(DEPTH));
    push        = enq_valid_i & enq_ready_o;
    wr_en       = push;
    pop_kill    = (head_state == HEAD_KILLED);
    pop         = pop_kill | ((head_state == HEAD_LIVE) & op_ack_i);
    op_rdy_o    = (head_state == HEAD_LIVE);
    op_id_o     = head_id;
    op_o        = head_op;
`ifdef VPROC_UNIT_QUEUE_BYPASS_EN
    // A killed op is not bypassed; it is written and dropped from the head.
    if ((head_state == HEAD_EMPTY) && enq_valid_i && !instr_killed_i[enq_id_i]) begin
      op_rdy_o = 1'b1;
      op_id_o  = enq_id_i;
      op_o     = enq_op_i;
      wr_en    = push & ~op_ack_i;
    end
`endif
  end

  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      rd_ptr            <= '0;
      wr_ptr            <= '0;
      count             <= '0;
      kill_done_valid_o <= 1'b0;
      kill_done_id_o    <= '0;
      vreg_pend_wr_o    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      kill_done_valid_o <= pop_kill;
      if (pop_kill) kill_done_id_o <= head_id;
      vreg_pend_wr_o <= pend_next;
    end
  end

  assign count_o = count;

endmodule

// File: tb/tb_vproc_unit_queue.sv
module tb_vproc_unit_queue;

  localparam int DEPTH = 4;
  localparam int EW    = 3 + 64 + 32; // {id, op, pend}

  logic        clk;
  logic        async_rst_i;
  logic        enq_valid_i;
  logic        enq_ready_o;
  logic [2:0]  enq_id_i;
  logic [63:0] enq_op_i;
  logic [31:0] enq_pend_wr_i;
  logic        op_rdy_o;
  logic        op_ack_i;
  logic [2:0]  op_id_o;
  logic [63:0] op_o;
  logic [7:0]  instr_killed_i;
  logic        kill_done_valid_o;
  logic [2:0]  kill_done_id_o;
  logic [31:0] vreg_pend_wr_o;
  logic [2:0]  count_o;

  vproc_unit_queue #(
    .DEPTH(DEPTH), .XIF_ID_W(3), .XIF_ID_CNT(8), .OP_W(64)
  ) dut (
    .clk_i             (clk),
    .async_rst_i       (async_rst_i),
    .enq_valid_i       (enq_valid_i),
    .enq_ready_o       (enq_ready_o),
    .enq_id_i          (enq_id_i),
    .enq_op_i          (enq_op_i),
    .enq_pend_wr_i     (enq_pend_wr_i),
    .op_rdy_o          (op_rdy_o),
    .op_ack_i          (op_ack_i),
    .op_id_o           (op_id_o),
    .op_o              (op_o),
    .instr_killed_i    (instr_killed_i),
    .kill_done_valid_o (kill_done_valid_o),
    .kill_done_id_o    (kill_done_id_o),
    .vreg_pend_wr_o    (vreg_pend_wr_o),
    .count_o           (count_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];      // queued ops, oldest first
  logic          exp_kd_valid;  // kill report due this cycle
  logic [2:0]    exp_kd_id;
  int            n_tests;
  int            n_fail;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs against the model,
  // then advance the model by what this cycle's edge will do.
  task automatic step(input logic ev, input logic [2:0] id, input logic [63:0] op,
                      input logic [31:0] pend, input logic ack, input logic [7:0] kill);
    int            sz;
    logic [EW-1:0] h;
    logic [2:0]    h_id;
    logic          exp_rdy;
    logic [2:0]    exp_id;
    logic [63:0]   exp_op;
    logic [31:0]   exp_pend;
    logic          do_push;
    logic          new_kd;
    @(negedge clk);
    enq_valid_i    = ev;
    enq_id_i       = id;
    enq_op_i       = op;
    enq_pend_wr_i  = pend;
    op_ack_i       = ack;
    instr_killed_i = kill;
    #1;
    sz   = exp_q.size();
    h    = (sz > 0) ? exp_q[0] : '0;
    h_id = h[98:96];
    exp_rdy = (sz > 0) && !kill[h_id];
    exp_id  = h_id;
    exp_op  = h[95:32];
`ifdef VPROC_UNIT_QUEUE_BYPASS_EN
    if (sz == 0 && ev && !kill[id]) begin
      exp_rdy = 1'b1;
      exp_id  = id;
      exp_op  = op;
    end
`endif
    exp_pend = '0;
    foreach (exp_q[i]) exp_pend = exp_pend | exp_q[i][31:0];

    check("count", 64'(count_o), 64'(sz));
    check("enq_ready", 64'(enq_ready_o), 64'(sz < DEPTH));
    check("op_rdy", 64'(op_rdy_o), 64'(exp_rdy));
    if (exp_rdy) begin
      check("op_id", 64'(op_id_o), 64'(exp_id));
      check("op", op_o, exp_op);
    end
    check("kd_valid", 64'(kill_done_valid_o), 64'(exp_kd_valid));
    if (exp_kd_valid) check("kd_id", 64'(kill_done_id_o), 64'(exp_kd_id));
    check("pend_wr", 64'(vreg_pend_wr_o), 64'(exp_pend));

    // model update: head first (kill beats ack), then enqueue
    new_kd  = 1'b0;
    do_push = ev && (sz < DEPTH);
    if (sz > 0) begin
      if (kill[h_id]) begin
        void'(exp_q.pop_front());
        new_kd    = 1'b1;
        exp_kd_id = h_id;
      end else if (ack) begin
        void'(exp_q.pop_front());
      end
    end
`ifdef VPROC_UNIT_QUEUE_BYPASS_EN
    if (sz == 0 && ev && !kill[id] && ack) do_push = 1'b0;
`endif
    if (do_push) exp_q.push_back({id, op, pend});
    exp_kd_valid = new_kd;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic drain();
    for (int i = 0; i < 8; i++) step(1'b0, 3'd0, 64'd0, 32'd0, 1'b1, 8'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_op_rdy"}, 64'(op_rdy_o), 64'd0);
    check({tag, "_kd_valid"}, 64'(kill_done_valid_o), 64'd0);
    check({tag, "_kd_id"}, 64'(kill_done_id_o), 64'd0);
    check({tag, "_pend_wr"}, 64'(vreg_pend_wr_o), 64'd0);
    check({tag, "_count"}, 64'(count_o), 64'd0);
    check({tag, "_enq_ready"}, 64'(enq_ready_o), 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] kill;
    logic [2:0] kid;
    n_tests = 0;
    n_fail  = 0;
    exp_kd_valid = 1'b0;
    exp_kd_id    = '0;
    async_rst_i    = 1'b1;
    enq_valid_i    = 1'b0;
    enq_id_i       = '0;
    enq_op_i       = '0;
    enq_pend_wr_i  = '0;
    op_ack_i       = 1'b0;
    instr_killed_i = '0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    async_rst_i = 1'b0;

    // fill and drain
    for (int i = 0; i < 4; i++) step(1'b1, 3'(i), rnd64(), 32'd0, 1'b0, 8'd0);
    step(1'b1, 3'd7, rnd64(), 32'd0, 1'b0, 8'd0);  // offered while full
    for (int i = 0; i < 4; i++) step(1'b0, 3'd0, 64'd0, 32'd0, 1'b1, 8'd0);
    step(1'b0, 3'd0, 64'd0, 32'd0, 1'b0, 8'd0);

    // pending mask
    step(1'b1, 3'd0, rnd64(), 32'h0000_0003, 1'b0, 8'd0);
    step(1'b1, 3'd1, rnd64(), 32'h0000_0030, 1'b0, 8'd0);
    step(1'b0, 3'd0, 64'd0, 32'd0, 1'b1, 8'd0);
    step(1'b0, 3'd0, 64'd0, 32'd0, 1'b0, 8'd0);
    drain();

    // kill at head
    step(1'b1, 3'd2, rnd64(), 32'h0000_0100, 1'b0, 8'd0);
    step(1'b1, 3'd5, rnd64(), 32'h0000_0200, 1'b0, 8'd0);
    step(1'b0, 3'd0, 64'd0, 32'd0, 1'b0, 8'b0000_0100);
    step(1'b0, 3'd0, 64'd0, 32'd0, 1'b0, 8'b0000_0100);
    step(1'b0, 3'd0, 64'd0, 32'd0, 1'b1, 8'd0);
    drain();

    // wrap-around with simultaneous enqueue and ack at count 2
    step(1'b1, 3'd0, rnd64(), 32'h1, 1'b0, 8'd0);
    step(1'b1, 3'd1, rnd64(), 32'h2, 1'b0, 8'd0);
    for (int k = 2; k < 12; k++) step(1'b1, 3'(k % 8), rnd64(), 32'(1 << k), 1'b1, 8'd0);
    drain();

    // full with pop
    for (int i = 0; i < 4; i++) step(1'b1, 3'(i + 4), rnd64(), 32'(1 << (i + 8)), 1'b0, 8'd0);
    step(1'b1, 3'd3, rnd64(), 32'h8000_0000, 1'b1, 8'd0);
    step(1'b1, 3'd3, rnd64(), 32'h8000_0000, 1'b0, 8'd0);
    step(1'b0, 3'd0, 64'd0, 32'd0, 1'b0, 8'd0);
    drain();

    // randomized traffic with kills
    for (int n = 0; n < 600; n++) begin
      kill = '0;
      case ($urandom_range(0, 9))
        0: begin kid = 3'($urandom_range(0, 7)); kill[kid] = 1'b1; end
        1, 2: if (exp_q.size() > 0) begin kid = exp_q[0][98:96]; kill[kid] = 1'b1; end
        default: ;
      endcase
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), rnd64(),
           $urandom, 1'($urandom_range(0, 9) < 6), kill);
    end
    drain();

    // reset mid-operation with a kill pending at the head
    for (int i = 0; i < 3; i++) step(1'b1, 3'(i), rnd64(), 32'(3 << i), 1'b0, 8'd0);
    @(negedge clk);
    enq_valid_i    = 1'b0;
    op_ack_i       = 1'b0;
    instr_killed_i = 8'b0000_0001;
    #2;
    async_rst_i = 1'b1;
    #1;
    check_reset_values("midrst");
    exp_q.delete();
    exp_kd_valid = 1'b0;
    @(posedge clk);
    #1;
    check_reset_values("midrst_hold");
    @(negedge clk);
    instr_killed_i = '0;
    async_rst_i    = 1'b0;
    step(1'b1, 3'd6, rnd64(), 32'h0000_0040, 1'b1, 8'd0);  // enqueue+ack while empty
    step(1'b0, 3'd0, 64'd0, 32'd0, 1'b0, 8'd0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety bound so the run always terminates.
  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
